// File: rtl/bthowen_pkg.sv
// Shared constants, FSM state type and the class weight masks for the BTHOWeN classifier.
package bthowen_pkg;

  localparam int INPUT_BITS  = 512;
  localparam int NUM_CLASSES = 10;
  localparam int CLASS_BITS  = 4;
  localparam int SCORE_BITS  = $clog2(INPUT_BITS + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_e;

  typedef logic [NUM_CLASSES-1:0][INPUT_BITS-1:0] weight_t;

  // Default model: input bit i votes for class (i mod NUM_CLASSES); trained masks are generated into this constant.
  function automatic weight_t gen_weights();
    weight_t w;
    w = '0;
    for (int i = 0; i < INPUT_BITS; i++) begin
      w[i % NUM_CLASSES][i] = 1'b1;
    end
    return w;
  endfunction

  localparam weight_t W = gen_weights();

endpackage

// File: rtl/bthowen_classifier_if_popcount512.sv
// Combinational population count of one masked sample, built as a pairwise adder tree.
module popcount512
  import bthowen_pkg::*;
(
  input  logic [INPUT_BITS-1:0] data_i,
  output logic [SCORE_BITS-1:0] count_o
);

  localparam int LEVELS = $clog2(INPUT_BITS);

  logic [SCORE_BITS-1:0] lvl [LEVELS+1][INPUT_BITS];

  // Each level halves the live node count; nodes past the live range stay zero.
  always_comb begin
    for (int k = 0; k < INPUT_BITS; k++) begin
      lvl[0][k] = SCORE_BITS'(data_i[k]);
    end
    for (int l = 1; l <= LEVELS; l++) begin
      for (int k = 0; k < INPUT_BITS; k++) begin
        lvl[l][k] = '0;
      end
      for (int k = 0; k < INPUT_BITS / 2; k++) begin
        lvl[l][k] = lvl[l-1][2*k] + lvl[l-1][2*k+1];
      end
    end
  end

  assign count_o = lvl[LEVELS][0];

endmodule

// File: rtl/bthowen_classifier_if.sv
// BTHOWeN sample intake + argmax scoring engine. Define BTHOWEN_PARALLEL_SCORE_EN to score
// all classes in a single COMPUTE cycle; otherwise one class is scored per cycle.
module bthowen_classifier_if
  import bthowen_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inp_vld,
  input  logic [INPUT_BITS-1:0] inp,
  output logic                  stall,
  output logic                  outp_vld,
  output logic [CLASS_BITS-1:0] outp,
  output state_e                dbg_state_o
);

  // Handshake: a sample transfers on a rising edge where inp_vld && !stall; while stall is
  // high the host holds inp/inp_vld. outp_vld is a one-cycle strobe qualifying outp.

  localparam logic [CLASS_BITS-1:0] LAST_CLASS = CLASS_BITS'(NUM_CLASSES - 1);

  state_e                  state_q, state_d;
  logic [INPUT_BITS-1:0]   sample_q, sample_d;
  logic [SCORE_BITS-1:0]   best_q, best_d;
  logic [CLASS_BITS-1:0]   best_idx_q, best_idx_d;
  logic [CLASS_BITS-1:0]   cnt_q, cnt_d;
  logic [CLASS_BITS-1:0]   outp_q, outp_d;

  logic [SCORE_BITS-1:0]   step_best;
  logic [CLASS_BITS-1:0]   step_idx;
  logic                    step_last;

`ifdef BTHOWEN_PARALLEL_SCORE_EN
  logic [SCORE_BITS-1:0] score_all [NUM_CLASSES];

  for (genvar c = 0; c < NUM_CLASSES; c++) begin : g_pc
    popcount512 u_pc (
      .data_i  (sample_q & W[c]),
      .count_o (score_all[c])
    );
  end

  // Strictly-greater replacement walked from class 0 keeps the lowest index on ties.
  always_comb begin
    step_best = best_q;
    step_idx  = best_idx_q;
    for (int c = 0; c < NUM_CLASSES; c++) begin
      if (score_all[c] > step_best) begin
        step_best = score_all[c];
        step_idx  = CLASS_BITS'(c);
      end
    end
  end

  assign step_last = 1'b1;
`else
  logic [SCORE_BITS-1:0] score;

  popcount512 u_pc (
    .data_i  (sample_q & W[cnt_q]),
    .count_o (score)
  );

  always_comb begin
    step_best = best_q;
    step_idx  = best_idx_q;
    if (score > best_q) begin
      step_best = score;
      step_idx  = cnt_q;
    end
  end

  assign step_last = (cnt_q == LAST_CLASS);
`endif

  always_comb begin
    state_d    = state_q;
    sample_d   = sample_q;
    best_d     = best_q;
    best_idx_d = best_idx_q;
    cnt_d      = cnt_q;
    outp_d     = outp_q;
    stall      = 1'b1;
    outp_vld   = 1'b0;
    case (state_q)
      IDLE: begin
        stall = 1'b0;
        if (inp_vld) begin
          sample_d   = inp;
          best_d     = '0;
          best_idx_d = '0;
          cnt_d      = '0;
          state_d    = COMPUTE;
        end
      end
      COMPUTE: begin
        best_d     = step_best;
        best_idx_d = step_idx;
        if (step_last) begin
          outp_d  = step_idx;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        outp_vld = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sample_q   <= '0;
      best_q     <= '0;
      best_idx_q <= '0;
      cnt_q      <= '0;
      outp_q     <= '0;
    end else begin
      state_q    <= state_d;
      sample_q   <= sample_d;
      best_q     <= best_d;
      best_idx_q <= best_idx_d;
      cnt_q      <= cnt_d;
      outp_q     <= outp_d;
    end
  end

  assign outp        = outp_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_bthowen_classifier_if.sv
// Directed bench for bthowen_classifier_if: hand-computed vectors, random stream vs. bit-loop model.
module tb_bthowen_classifier_if;

`ifdef BTHOWEN_PARALLEL_SCORE_EN
  localparam int LAT    = 2;
  localparam int PERIOD = 3;
`else
  localparam int LAT    = 11;
  localparam int PERIOD = 12;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         inp_vld;
  logic [511:0] inp;
  logic         stall;
  logic         outp_vld;
  logic [3:0]   outp;
  bthowen_pkg::state_e dbg_state;

  int vecs = 0;
  int errs = 0;
  int cyc = 0;
  int n_results = 0;
  int last_acc = 0;

  logic [3:0] exp_q[$];
  int         acc_q[$];

  bthowen_classifier_if dut (
    .clk         (clk),
    .rst         (rst),
    .inp_vld     (inp_vld),
    .inp         (inp),
    .stall       (stall),
    .outp_vld    (outp_vld),
    .outp        (outp),
    .dbg_state_o (dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vecs++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Reference: input bit i votes for class i%10; strictly greater wins.
  function automatic logic [3:0] ref_class(input logic [511:0] s);
    int sc [10];
    int best;
    logic [3:0] idx;
    for (int c = 0; c < 10; c++) sc[c] = 0;
    for (int i = 0; i < 512; i++) if (s[i]) sc[i % 10]++;
    best = 0;
    idx  = 4'd0;
    for (int c = 0; c < 10; c++) begin
      if (sc[c] > best) begin
        best = sc[c];
        idx  = 4'(c);
      end
    end
    return idx;
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int k = 0; k < 16; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  // scoreboard
  always @(negedge clk) begin
    logic [3:0] e;
    int a;
    if (outp_vld === 1'b1) begin
      n_results++;
      check("vld_has_pending", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        a = acc_q.pop_front();
        check("outp", 32'(outp), 32'(e));
        check("latency", cyc - a, LAT);
      end
    end
  end

  // driver tasks
  task automatic send(input logic [511:0] d, input logic [3:0] e, input bit track, input bit keep);
    bit acc;
    int t;
    acc = 1'b0;
    t = 0;
    @(posedge clk); #1;
    inp     = d;
    inp_vld = 1'b1;
    while (!acc && t < 64) begin
      @(negedge clk);
      if (stall === 1'b0) begin
        acc      = 1'b1;
        last_acc = cyc;
        if (track) begin
          exp_q.push_back(e);
          acc_q.push_back(cyc);
        end
      end
      @(posedge clk); #1;
      t++;
    end
    if (!keep) inp_vld = 1'b0;
    check("accepted", 32'(acc), 1);
    @(negedge clk);
    check("stall_after_accept", 32'(stall), 1);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    check("drain", exp_q.size(), 0);
    repeat (2) @(negedge clk);
    check("stall_idle", 32'(stall), 0);
  endtask

  initial begin
    logic [511:0] d;
    int n0;
    int prev;

    rst     = 1'b1;
    inp_vld = 1'b0;
    inp     = 512'd42;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_stall", 32'(stall), 0);
    check("rst_vld", 32'(outp_vld), 0);
    check("rst_outp", 32'(outp), 0);
    check("rst_state", 32'(dbg_state), 32'(bthowen_pkg::IDLE));
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_vld", 32'(outp_vld), 0);
      check("idle_stall", 32'(stall), 0);
      check("idle_outp", 32'(outp), 0);
    end

    n0 = n_results;
    send(512'h0BC614E, 4'd3, 1'b1, 1'b0);
    drain();
    repeat (3) @(negedge clk);
    check("single_result", n_results - n0, 1);

    send(512'd42, 4'd1, 1'b1, 1'b0);
    drain();
    check("outp_hold", 32'(outp), 1);
    send(512'd0, 4'd0, 1'b1, 1'b0);
    drain();
    send({512{1'b1}}, 4'd0, 1'b1, 1'b0);
    drain();
    d = '0;
    d[509] = 1'b1;
    send(d, 4'd9, 1'b1, 1'b0);
    drain();
    d = '0;
    d[17] = 1'b1;
    send(d, 4'd7, 1'b1, 1'b0);
    drain();

    n0 = n_results;
    prev = 0;
    for (int n = 0; n < 16; n++) begin
      d = rand512();
      send(d, ref_class(d), 1'b1, 1'b1);
      if (n > 0) check("stream_spacing", last_acc - prev, PERIOD);
      prev = last_acc;
    end
    inp_vld = 1'b0;
    drain();
    check("stream_count", n_results - n0, 16);

    send(512'd42, 4'd1, 1'b1, 1'b0);
    drain();
    n0 = n_results;
    d = '0;
    d[509] = 1'b1;
    send(d, 4'd9, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_stall", 32'(stall), 0);
    check("abort_outp", 32'(outp), 0);
    check("abort_vld", 32'(outp_vld), 0);
    repeat (15) @(negedge clk);
    check("abort_no_result", n_results - n0, 0);
    send(512'h0BC614E, 4'd3, 1'b1, 1'b0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
